// File: rtl/adc_stream_pkg.sv
// Shared definitions for ADC-format AXI4-Stream producers: sample geometry,
// the unpacked-to-lane packing function and the playback FSM states.
package adc_stream_pkg;

    localparam int SAMPLE_BITS = 12;
    localparam int LANE_BITS   = 16;
    localparam int NSAMP       = 8;
    localparam int WORD_BITS   = SAMPLE_BITS * NSAMP;
    localparam int BEAT_BITS   = LANE_BITS * NSAMP;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } pb_state_e;

    // Each sample lands MSB-aligned in its 16-bit lane; the low bits stay zero.
    function automatic logic [BEAT_BITS-1:0] pack96to128(input logic [WORD_BITS-1:0] w);
        logic [BEAT_BITS-1:0] b;
        b = '0;
        for (int i = 0; i < NSAMP; i++) begin
            b[LANE_BITS*i + (LANE_BITS-SAMPLE_BITS) +: SAMPLE_BITS] = w[SAMPLE_BITS*i +: SAMPLE_BITS];
        end
        return b;
    endfunction

endpackage

// File: rtl/playback_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read colliding with a write to the same address returns the old word.
module playback_ram
    import adc_stream_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = WORD_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];
    logic [DATA_BITS-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/adc_stream_playback.sv
// Replays a RAM block of unpacked sample words as packed ADC-format stream
// beats, once or looped, with a 2-entry output stage for zero-bubble backpressure.
module adc_stream_playback
    import adc_stream_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_we,
    input  logic [DEPTH_LOG2-1:0] cfg_addr,
    input  logic [WORD_BITS-1:0]  cfg_wdata,
    input  logic [DEPTH_LOG2:0]   len_i,
    input  logic                  loop_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic [BEAT_BITS-1:0]  m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           pass_count_o
);

    localparam logic [DEPTH_LOG2:0] LEN_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    pb_state_e state_reg, state_next;

    logic [DEPTH_LOG2-1:0] ptr_reg, ptr_next;
    logic [DEPTH_LOG2-1:0] last_addr_reg, last_addr_next;
    logic                  loop_reg, loop_next;
    logic                  pend_reg, pend_next;
    logic                  pend_last_reg, pend_last_next;
    logic                  skid_valid_reg, skid_valid_next;
    logic [WORD_BITS-1:0]  skid_data_reg, skid_data_next;
    logic                  skid_last_reg, skid_last_next;
    logic                  tvalid_reg, tvalid_next;
    logic [BEAT_BITS-1:0]  tdata_reg, tdata_next;
    logic                  tlast_reg, tlast_next;
    logic [15:0]           pass_cnt_reg, pass_cnt_next;
    logic                  done_reg, done_next;

    logic                  accept, pop, pop_last, issue, rd_en;
    logic [1:0]            occ;
    logic [DEPTH_LOG2-1:0] start_last_addr, rd_addr, ptr_wrap;
    logic [WORD_BITS-1:0]  rd_data;

    playback_ram #(
        .ADDR_BITS (DEPTH_LOG2),
        .DATA_BITS (WORD_BITS)
    ) u_ram (
        .clk   (aclk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Lengths at or above the RAM size play the whole RAM.
    assign start_last_addr = (len_i >= LEN_MAX) ? {DEPTH_LOG2{1'b1}}
                                                : len_i[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
    assign accept   = (state_reg == ST_IDLE) && start_i && !stop_i && (len_i != '0);
    assign pop      = tvalid_reg && m_tready;
    assign pop_last = pop && tlast_reg;
    assign ptr_wrap = (ptr_reg == last_addr_reg) ? '0 : ptr_reg + DEPTH_LOG2'(1);

    // Words held plus the one in flight from RAM never exceed the two slots.
    assign occ   = 2'(tvalid_reg) + 2'(skid_valid_reg) + 2'(pend_reg);
    assign issue = ((state_reg == ST_PRIME) || (state_reg == ST_STREAM && !stop_i))
                   && ((occ - 2'(pop)) < 2'd2);

    // Word 0 is fetched on the accepting edge so it reaches the output two cycles later.
    assign rd_en   = accept || issue;
    assign rd_addr = accept ? '0 : ptr_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_PRIME;
            ST_PRIME:  state_next = ST_STREAM;
            ST_STREAM: begin
                if (pop_last && !loop_reg) state_next = ST_IDLE;
                else if (stop_i)           state_next = ST_FLUSH;
            end
            ST_FLUSH:  if (!tvalid_reg || pop) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_next        = ptr_reg;
        last_addr_next  = last_addr_reg;
        loop_next       = loop_reg;
        pend_next       = 1'b0;
        pend_last_next  = pend_last_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_last_next  = skid_last_reg;
        tvalid_next     = tvalid_reg;
        tdata_next      = tdata_reg;
        tlast_next      = tlast_reg;
        pass_cnt_next   = pass_cnt_reg;
        done_next       = (state_reg != ST_IDLE) && (state_next == ST_IDLE);

        if (accept) begin
            ptr_next       = (start_last_addr == '0) ? '0 : DEPTH_LOG2'(1);
            last_addr_next = start_last_addr;
            loop_next      = loop_i;
            pend_next      = 1'b1;
            pend_last_next = (start_last_addr == '0);
        end else if (issue) begin
            ptr_next       = ptr_wrap;
            pend_next      = 1'b1;
            pend_last_next = (ptr_reg == last_addr_reg);
        end

        if (state_next == ST_IDLE) begin
            tvalid_next     = 1'b0;
            skid_valid_next = 1'b0;
            pend_next       = accept;
        end else if (state_next == ST_FLUSH) begin
            // Only the beat already on the bus survives a stop.
            tvalid_next     = tvalid_reg && !pop;
            skid_valid_next = 1'b0;
            pend_next       = 1'b0;
        end else if (!tvalid_reg || pop) begin
            if (skid_valid_reg) begin
                tvalid_next     = 1'b1;
                tdata_next      = pack96to128(skid_data_reg);
                tlast_next      = skid_last_reg;
                skid_valid_next = pend_reg;
                skid_data_next  = rd_data;
                skid_last_next  = pend_last_reg;
            end else if (pend_reg) begin
                tvalid_next = 1'b1;
                tdata_next  = pack96to128(rd_data);
                tlast_next  = pend_last_reg;
            end else begin
                tvalid_next = 1'b0;
            end
        end else if (pend_reg) begin
            skid_valid_next = 1'b1;
            skid_data_next  = rd_data;
            skid_last_next  = pend_last_reg;
        end

        if (accept) begin
            pass_cnt_next = '0;
        end else if (pop_last && pass_cnt_reg != 16'hFFFF) begin
            pass_cnt_next = pass_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            last_addr_reg  <= '0;
            loop_reg       <= 1'b0;
            pend_reg       <= 1'b0;
            pend_last_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_last_reg  <= 1'b0;
            tvalid_reg     <= 1'b0;
            tdata_reg      <= '0;
            tlast_reg      <= 1'b0;
            pass_cnt_reg   <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            last_addr_reg  <= last_addr_next;
            loop_reg       <= loop_next;
            pend_reg       <= pend_next;
            pend_last_reg  <= pend_last_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_last_reg  <= skid_last_next;
            tvalid_reg     <= tvalid_next;
            tdata_reg      <= tdata_next;
            tlast_reg      <= tlast_next;
            pass_cnt_reg   <= pass_cnt_next;
            done_reg       <= done_next;
        end
    end

    assign m_tdata      = tdata_reg;
    assign m_tvalid     = tvalid_reg;
    assign m_tlast      = tlast_reg;
    assign busy_o       = (state_reg != ST_IDLE);
    assign done_o       = done_reg;
    assign pass_count_o = pass_cnt_reg;

endmodule

// File: tb/tb_adc_stream_playback.sv
// Bench for adc_stream_playback: table of playback runs checked against a
// RAM image and the stream rules, plus hand-written timing and corner sequences.
module tb_adc_stream_playback;

    localparam int D     = 10;
    localparam int DEPTH = 1 << D;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         cfg_we = 1'b0;
    logic [D-1:0] cfg_addr = '0;
    logic [95:0]  cfg_wdata = '0;
    logic [D:0]   len_i = '0;
    logic         loop_i = 1'b0;
    logic         start_i = 1'b0;
    logic         stop_i = 1'b0;
    logic         m_tready = 1'b0;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         busy_o;
    logic         done_o;
    logic [15:0]  pass_count_o;

    always #5 aclk = ~aclk;

    adc_stream_playback #(.DEPTH_LOG2(D)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .len_i        (len_i),
        .loop_i       (loop_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_count_o (pass_count_o)
    );

    typedef struct {
        int len;
        bit loop;
        int pct;
        int stop_after;
        bit dbl;
        int exp_beats;
        int exp_pass;
    } vec_t;

    logic [95:0] mem_model [DEPTH];
    vec_t        vecs [12];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_ref(input logic [95:0] w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = {w[12*i +: 12], 4'h0};
        return r;
    endfunction

    task automatic write_word(input int k, input logic [95:0] w);
        @(negedge aclk);
        cfg_we    = 1'b1;
        cfg_addr  = D'(k);
        cfg_wdata = w;
        mem_model[k] = w;
    endtask

    task automatic write_done();
        @(negedge aclk);
        cfg_we = 1'b0;
    endtask

    // One playback run; every accepted beat is checked against the RAM image.
    task automatic run_vec(input int idx, input vec_t v);
        int eff_len, beats, cyc, bubbles, flush_wait, b;
        bit held, seen_valid, stopping, finished, last_hs, rdy, hs;
        logic [127:0] hd;
        logic hl;
        eff_len = (v.len > DEPTH) ? DEPTH : v.len;
        beats = 0; cyc = 0; bubbles = 0; flush_wait = 0;
        held = 0; seen_valid = 0; stopping = 0; finished = 0; last_hs = 0;
        hd = '0; hl = 1'b0;
        @(negedge aclk);
        len_i = (D+1)'(v.len); loop_i = v.loop; start_i = 1'b1; stop_i = 1'b0; m_tready = 1'b0;
        while (!finished && cyc < 5000) begin
            @(negedge aclk);
            cyc++;
            if (done_o) begin
                chk($sformatf("v%0d_done_after_hs", idx), 128'(last_hs), 128'(1));
                chk($sformatf("v%0d_busy_at_done", idx), 128'(busy_o), 128'(0));
                chk($sformatf("v%0d_tvalid_at_done", idx), 128'(m_tvalid), 128'(0));
                finished = 1;
                start_i = 1'b0; stop_i = 1'b0; m_tready = 1'b0;
            end else begin
                if (held) begin
                    chk($sformatf("v%0d_hold_valid", idx), 128'(m_tvalid), 128'(1));
                    chk($sformatf("v%0d_hold_data", idx), m_tdata, hd);
                    chk($sformatf("v%0d_hold_last", idx), 128'(m_tlast), 128'(hl));
                end
                if (m_tvalid) seen_valid = 1;
                if (v.pct == 100 && seen_valid && !stopping && !m_tvalid) bubbles++;
                rdy = ($urandom_range(99) < v.pct);
                start_i = 1'b0;
                if (v.dbl && cyc == 3) begin
                    start_i = 1'b1; len_i = (D+1)'(3); loop_i = 1'b1;
                end
                stop_i = 1'b0;
                if (stopping) begin
                    rdy = (flush_wait >= 3);
                    flush_wait++;
                end else if (v.stop_after > 0 && beats == v.stop_after) begin
                    stopping = 1; stop_i = 1'b1; rdy = 1'b0; flush_wait = 1;
                end
                hs = m_tvalid && rdy;
                if (hs) begin
                    b = beats % eff_len;
                    chk($sformatf("v%0d_beat%0d_data", idx, beats), m_tdata, pack_ref(mem_model[b]));
                    chk($sformatf("v%0d_beat%0d_last", idx, beats), 128'(m_tlast), 128'(b == eff_len - 1));
                    beats++;
                end
                held = m_tvalid && !rdy;
                hd = m_tdata;
                hl = m_tlast;
                last_hs = hs;
                m_tready = rdy;
            end
        end
        chk($sformatf("v%0d_finished_in_budget", idx), 128'(finished), 128'(1));
        chk($sformatf("v%0d_beat_count", idx), 128'(beats), 128'(v.exp_beats));
        chk($sformatf("v%0d_pass_count", idx), 128'(pass_count_o), 128'(v.exp_pass));
        if (v.pct == 100) chk($sformatf("v%0d_bubbles", idx), 128'(bubbles), 128'(0));
        @(negedge aclk);
        chk($sformatf("v%0d_done_one_cycle", idx), 128'(done_o), 128'(0));
        last_pass = v.exp_pass;
        $display("vec %0d: len %0d loop %0d ready %0d%% beats %0d passes %0d cycles %0d",
                 idx, v.len, v.loop, v.pct, beats, pass_count_o, cyc);
    endtask

    task automatic no_start(input string nm, input int len, input bit stp);
        @(negedge aclk);
        len_i = (D+1)'(len); loop_i = 1'b0; start_i = 1'b1; stop_i = stp; m_tready = 1'b1;
        @(negedge aclk);
        start_i = 1'b0; stop_i = 1'b0;
        chk({nm, "_busy1"}, 128'(busy_o), 128'(0));
        @(negedge aclk);
        chk({nm, "_busy2"}, 128'(busy_o), 128'(0));
        chk({nm, "_done"}, 128'(done_o), 128'(0));
        chk({nm, "_tvalid"}, 128'(m_tvalid), 128'(0));
        chk({nm, "_pass_kept"}, 128'(pass_count_o), 128'(last_pass));
        m_tready = 1'b0;
        $display("edge start %s: len %0d stop %0d busy %0d", nm, len, stp, busy_o);
    endtask

    initial begin
        logic [95:0]  w;
        logic [127:0] exp0;

        repeat (3) @(negedge aclk);
        chk("rst_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_tdata", m_tdata, 128'(0));
        chk("rst_tlast", 128'(m_tlast), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_pass", 128'(pass_count_o), 128'(0));
        aresetn = 1'b1;

        for (int k = 0; k < DEPTH; k++) write_word(k, {$urandom(), $urandom(), $urandom()});
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 8; i++) w[12*i +: 12] = 12'(16*k + i);
            write_word(k, w);
        end
        write_done();

        // Single pass of 4 words with exact cycle timing.
        exp0 = '0;
        for (int i = 0; i < 8; i++) exp0[16*i +: 16] = 16'(i << 4);
        @(negedge aclk);
        len_i = (D+1)'(4); loop_i = 1'b0; start_i = 1'b1; m_tready = 1'b1;
        @(negedge aclk);
        start_i = 1'b0;
        chk("t1_busy_n1", 128'(busy_o), 128'(1));
        chk("t1_tvalid_n1", 128'(m_tvalid), 128'(0));
        for (int bt = 0; bt < 4; bt++) begin
            @(negedge aclk);
            chk($sformatf("t1_valid_b%0d", bt), 128'(m_tvalid), 128'(1));
            chk($sformatf("t1_data_b%0d", bt), m_tdata, (bt == 0) ? exp0 : pack_ref(mem_model[bt]));
            chk($sformatf("t1_last_b%0d", bt), 128'(m_tlast), 128'(bt == 3));
        end
        @(negedge aclk);
        chk("t1_done_n6", 128'(done_o), 128'(1));
        chk("t1_busy_n6", 128'(busy_o), 128'(0));
        chk("t1_tvalid_n6", 128'(m_tvalid), 128'(0));
        chk("t1_pass", 128'(pass_count_o), 128'(1));
        m_tready = 1'b0;
        last_pass = 1;
        $display("t1: len 4 single pass, pass_count %0d", pass_count_o);

        vecs[0]  = '{len: 4,    loop: 0, pct: 100, stop_after: 0,  dbl: 0, exp_beats: 4,    exp_pass: 1};
        vecs[1]  = '{len: 3,    loop: 1, pct: 100, stop_after: 11, dbl: 0, exp_beats: 12,   exp_pass: 4};
        vecs[2]  = '{len: 16,   loop: 0, pct: 50,  stop_after: 0,  dbl: 0, exp_beats: 16,   exp_pass: 1};
        vecs[3]  = '{len: 1,    loop: 0, pct: 100, stop_after: 0,  dbl: 0, exp_beats: 1,    exp_pass: 1};
        vecs[4]  = '{len: 1,    loop: 1, pct: 60,  stop_after: 9,  dbl: 0, exp_beats: 10,   exp_pass: 10};
        vecs[5]  = '{len: 7,    loop: 1, pct: 50,  stop_after: 20, dbl: 0, exp_beats: 21,   exp_pass: 3};
        vecs[6]  = '{len: 1025, loop: 0, pct: 100, stop_after: 0,  dbl: 0, exp_beats: 1024, exp_pass: 1};
        vecs[7]  = '{len: 8,    loop: 0, pct: 100, stop_after: 0,  dbl: 1, exp_beats: 8,    exp_pass: 1};
        vecs[8]  = '{len: 5,    loop: 1, pct: 30,  stop_after: 13, dbl: 0, exp_beats: 14,   exp_pass: 2};
        vecs[9]  = '{len: 1024, loop: 0, pct: 80,  stop_after: 0,  dbl: 0, exp_beats: 1024, exp_pass: 1};
        for (int j = 10; j < 12; j++) begin
            vecs[j].len = int'($urandom_range(60, 2));
            vecs[j].loop = 0;
            vecs[j].pct = int'($urandom_range(90, 20));
            vecs[j].stop_after = 0;
            vecs[j].dbl = 0;
            vecs[j].exp_beats = vecs[j].len;
            vecs[j].exp_pass = 1;
        end

        for (int j = 0; j < 12; j++) begin
            for (int r = 0; r < 3; r++) write_word(int'($urandom_range(63)), {$urandom(), $urandom(), $urandom()});
            write_done();
            run_vec(j, vecs[j]);
        end

        no_start("len_zero", 0, 1'b0);
        no_start("start_with_stop", 4, 1'b1);

        // Reset in the middle of a looped run, then replay from word 0.
        @(negedge aclk);
        len_i = (D+1)'(5); loop_i = 1'b1; start_i = 1'b1; m_tready = 1'b1;
        @(negedge aclk);
        start_i = 1'b0;
        repeat (6) @(negedge aclk);
        chk("mid_tvalid_before_rst", 128'(m_tvalid), 128'(1));
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 128'(m_tvalid), 128'(0));
        chk("mid_rst_tdata", m_tdata, 128'(0));
        chk("mid_rst_tlast", 128'(m_tlast), 128'(0));
        chk("mid_rst_busy", 128'(busy_o), 128'(0));
        chk("mid_rst_done", 128'(done_o), 128'(0));
        chk("mid_rst_pass", 128'(pass_count_o), 128'(0));
        $display("mid-stream reset: tvalid %0d busy %0d pass %0d", m_tvalid, busy_o, pass_count_o);
        m_tready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        run_vec(12, '{len: 2, loop: 0, pct: 100, stop_after: 0, dbl: 0, exp_beats: 2, exp_pass: 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
